// File: rtl/fdiv_result_pack.sv
// fdiv_result_pack
// Output stage of the single-precision divider. Captures the divider's
// split result fields, packs them into an IEEE-754 single, and buffers them
// in a two-entry valid/ready queue. Also keeps sticky exception flags and a
// count of results handed to the consumer.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        divider-side handshake
//   in_sign, in_exp, in_frac   raw result fields (in_frac[23] is ignored)
//   in_error, in_overflow,
//   in_dbz                     exception qualifiers
//   out_valid / out_ready      consumer-side handshake
//   out_result, out_flags      packed word and its {invalid, dbz, ovf}
//   sticky_flags, flag_clr     accumulated flags and their clear
//   ops_done                   output handshake counter (wraps)
module fdiv_result_pack #(
  parameter int          DEPTH = 2,
  parameter int          CNT_W = 16,
  parameter logic [31:0] QNAN  = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [7:0]       in_exp,
  input  logic [23:0]      in_frac,
  input  logic             in_error,
  input  logic             in_overflow,
  input  logic             in_dbz,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [2:0]       out_flags,
  output logic [2:0]       sticky_flags,
  input  logic             flag_clr,
  output logic [CNT_W-1:0] ops_done
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  // Queue entry layout: {result[31:0], flags[2:0]}
  logic [34:0]      head_q, head_d;
  logic [34:0]      tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic [2:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] ops_q, ops_d;

  logic [31:0] pk_res;
  logic [2:0]  pk_flg;
  logic        push;
  logic        pop;

  // Bit 23 of the divider fraction is the hidden bit; it never reaches the word.
  logic unused_frac_msb;
  assign unused_frac_msb = in_frac[23];

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Exception priority: invalid > overflow > divide-by-zero > normal.
  always_comb begin
    pk_res = {in_sign, in_exp, in_frac[22:0]};
    pk_flg = 3'b000;
    if (in_error) begin
      pk_res = QNAN;
      pk_flg = 3'b100;
    end else if (in_overflow) begin
      pk_res = {in_sign, 8'hFF, 23'h0};
      pk_flg = 3'b001;
    end else if (in_dbz) begin
      pk_res = {in_sign, 8'hFF, 23'h0};
      pk_flg = 3'b010;
    end
  end

  // The head register doubles as the output register, so after the last pop
  // it simply keeps showing the most recent result.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case ({push, pop})
      2'b10: begin
        count_d = count_q + 2'd1;
        if (count_q == 2'd0) head_d = {pk_res, pk_flg};
        else                 tail_d = {pk_res, pk_flg};
      end
      2'b01: begin
        count_d = count_q - 2'd1;
        if (count_q == FULL) head_d = tail_q;
      end
      // Push and pop together can only happen with one entry queued.
      2'b11:   head_d = {pk_res, pk_flg};
      default: ;
    endcase
  end

  // A flagged accept in the same cycle as flag_clr leaves only its own flags.
  always_comb begin
    sticky_d = flag_clr ? 3'b000 : sticky_q;
    if (push) sticky_d = sticky_d | pk_flg;
    ops_d = ops_q + {{(CNT_W-1){1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      head_q   <= '0;
      tail_q   <= '0;
      sticky_q <= 3'b000;
      ops_q    <= '0;
    end else begin
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      sticky_q <= sticky_d;
      ops_q    <= ops_d;
    end
  end

  assign out_result   = head_q[34:3];
  assign out_flags    = head_q[2:0];
  assign sticky_flags = sticky_q;
  assign ops_done     = ops_q;

endmodule

// File: tb/tb_fdiv_result_pack.sv
// Testbench for fdiv_result_pack: directed vectors, a queue-based model
// compared on every falling edge, and literal expectations at key points.
module tb_fdiv_result_pack;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [7:0]       in_exp;
  logic [23:0]      in_frac;
  logic             in_error;
  logic             in_overflow;
  logic             in_dbz;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [2:0]       out_flags;
  logic [2:0]       sticky_flags;
  logic             flag_clr;
  logic [CNT_W-1:0] ops_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fdiv_result_pack #(.DEPTH(2), .CNT_W(CNT_W), .QNAN(32'h7FC00000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_frac      (in_frac),
    .in_error     (in_error),
    .in_overflow  (in_overflow),
    .in_dbz       (in_dbz),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .flag_clr     (flag_clr),
    .ops_done     (ops_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [34:0] mq[$];
  logic [31:0] m_res;
  logic [2:0]  m_flg;
  logic [2:0]  m_sticky;
  int          m_ops;

  function automatic logic [34:0] model_pack(input logic s, input logic [7:0] e,
                                             input logic [23:0] f, input logic err,
                                             input logic ovf, input logic dbz);
    logic [22:0] fr;
    fr = f[22:0];
    if (err) return {32'h7FC00000, 3'b100};
    if (ovf) return {s, 8'hFF, 23'h0, 3'b001};
    if (dbz) return {s, 8'hFF, 23'h0, 3'b010};
    return {s, e, fr, 3'b000};
  endfunction

  // Inputs change just after the rising edge, so at the falling edge they
  // are the values the next rising edge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_res = 32'h0; m_flg = 3'b000; m_sticky = 3'b000; m_ops = 0;
    end
    chk("mdl_out_valid", {31'h0, out_valid}, {31'h0, mq.size() > 0});
    chk("mdl_in_ready",  {31'h0, in_ready},  {31'h0, mq.size() < 2});
    chk("mdl_out_result", out_result, m_res);
    chk("mdl_out_flags", {29'h0, out_flags}, {29'h0, m_flg});
    chk("mdl_sticky", {29'h0, sticky_flags}, {29'h0, m_sticky});
    chk("mdl_ops_done", {28'h0, ops_done}, m_ops);
    if (rst_n) begin
      logic        do_pop, do_push;
      logic [34:0] ent;
      do_pop  = (mq.size() > 0) && out_ready;
      do_push = in_valid && (mq.size() < 2);
      ent     = model_pack(in_sign, in_exp, in_frac, in_error, in_overflow, in_dbz);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(ent);
      if (flag_clr) m_sticky = 3'b000;
      if (do_push) m_sticky = m_sticky | ent[2:0];
      if (do_pop) m_ops = (m_ops + 1) % (1 << CNT_W);
      if (mq.size() > 0) begin
        m_res = mq[0][34:3];
        m_flg = mq[0][2:0];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic s, input logic [7:0] e, input logic [23:0] f,
                        input logic err, input logic ovf, input logic dbz);
    in_valid = v; in_sign = s; in_exp = e; in_frac = f;
    in_error = err; in_overflow = ovf; in_dbz = dbz;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
    set_in(0, 0, 8'h00, 24'h0, 0, 0, 0);
    repeat (3) step();
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_sticky", {29'h0, sticky_flags}, 32'h0);
    chk("rst_ops", {28'h0, ops_done}, 32'h0);
    rst_n = 1'b1;
    step();
    $display("[TB] reset checked");

    // Normal pack, then a fraction with bit 23 set (must be dropped)
    out_ready = 1'b1;
    set_in(1, 0, 8'h7F, 24'h400000, 0, 0, 0);
    step();
    set_in(0, 0, 8'h00, 24'h0, 0, 0, 0);
    chk("norm_valid", {31'h0, out_valid}, 32'h1);
    chk("norm_result", out_result, 32'h3FC00000);
    chk("norm_flags", {29'h0, out_flags}, 32'h0);
    step();
    chk("norm_ops", {28'h0, ops_done}, 32'h1);
    set_in(1, 1, 8'h7F, 24'hC00001, 0, 0, 0);
    step();
    set_in(0, 0, 8'h00, 24'h0, 0, 0, 0);
    chk("frac23_result", out_result, 32'hBFC00001);
    step();
    $display("[TB] normal pack done");

    // Back-to-back exceptions
    set_in(1, 1, 8'h12, 24'h123456, 1, 1, 1);
    step();
    set_in(1, 1, 8'h34, 24'h0, 0, 1, 1);
    chk("exc_err_result", out_result, 32'h7FC00000);
    chk("exc_err_flags", {29'h0, out_flags}, 32'h4);
    step();
    set_in(1, 0, 8'h56, 24'h1, 0, 0, 1);
    chk("exc_ovf_result", out_result, 32'hFF800000);
    chk("exc_ovf_flags", {29'h0, out_flags}, 32'h1);
    step();
    set_in(0, 0, 8'h00, 24'h0, 0, 0, 0);
    chk("exc_dbz_result", out_result, 32'h7F800000);
    chk("exc_dbz_flags", {29'h0, out_flags}, 32'h2);
    chk("exc_sticky", {29'h0, sticky_flags}, 32'h7);
    step();
    $display("[TB] exceptions done");

    // Backpressure: A and B accepted, C blocked until space frees up
    out_ready = 1'b0;
    set_in(1, 0, 8'h80, 24'h0, 0, 0, 0);
    step();
    set_in(1, 1, 8'h81, 24'h200000, 0, 0, 0);
    step();
    set_in(1, 0, 8'h01, 24'h0, 0, 0, 0);
    chk("bp_full_ready", {31'h0, in_ready}, 32'h0);
    chk("bp_head", out_result, 32'h40000000);
    step();
    chk("bp_head_hold", out_result, 32'h40000000);
    chk("bp_valid_hold", {31'h0, out_valid}, 32'h1);
    out_ready = 1'b1;
    step();
    chk("bp_second", out_result, 32'hC0A00000);
    step();
    set_in(0, 0, 8'h00, 24'h0, 0, 0, 0);
    chk("bp_third", out_result, 32'h00800000);
    step();
    $display("[TB] backpressure done");

    // Streaming push+pop at occupancy 1
    for (int i = 0; i < 10; i++) begin
      set_in(1, i[0], 8'h70 + 8'(i), 24'(i), 0, 0, 0);
      step();
      chk("stream_ready", {31'h0, in_ready}, 32'h1);
    end
    set_in(0, 0, 8'h00, 24'h0, 0, 0, 0);
    step();
    chk("stream_ops", {28'h0, ops_done}, 32'h2);
    $display("[TB] streaming done");

    // flag_clr coincident with an overflow accept, then alone
    set_in(1, 0, 8'h00, 24'h0, 0, 1, 0);
    flag_clr = 1'b1;
    step();
    set_in(0, 0, 8'h00, 24'h0, 0, 0, 0);
    chk("clr_set_wins", {29'h0, sticky_flags}, 32'h1);
    step();
    flag_clr = 1'b0;
    chk("clr_alone", {29'h0, sticky_flags}, 32'h0);
    step();
    $display("[TB] flag clear done");

    // Reset with two entries queued
    out_ready = 1'b0;
    set_in(1, 0, 8'h90, 24'h0, 0, 0, 0);
    step();
    step();
    set_in(0, 0, 8'h00, 24'h0, 0, 0, 0);
    chk("pre_rst_full", {31'h0, in_ready}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("async_rst_result", out_result, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", {31'h0, in_ready}, 32'h1);
    chk("post_rst_ops", {28'h0, ops_done}, 32'h0);
    $display("[TB] mid-operation reset done");

    // Counter wrap: 16 output handshakes with CNT_W=4
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_in(1, 0, 8'h40 + 8'(i), 24'(i * 3), 0, 0, 0);
      step();
    end
    chk("wrap_pre", {28'h0, ops_done}, 32'hF);
    set_in(0, 0, 8'h00, 24'h0, 0, 0, 0);
    step();
    chk("wrap_zero", {28'h0, ops_done}, 32'h0);
    $display("[TB] counter wrap done");

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
